regfile_mp: RTL

- Parametrised multi-port register file, successor to the single-cycle core's 2R1W file.
- Provides configurable read ports, two write ports, registered reads with write-first bypass, optional hardwired zero register, and a per-register pending (scoreboard) bit.
- Sits between decode (read/alloc) and writeback (write) in the pipelined datapath.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 75 +++++++
 rtl/regfile_mp.sv | 96 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// the hardwired-zero default and an index-width helper.
package regfile_pkg;

    localparam int RF_DW       = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_AW       = 6;
    localparam int RF_NUM_RD   = 2;
    localparam int RF_ZERO_REG = 1;

    // Bits needed to index DEPTH entries (at least one).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port. Looks up the addressed register and its pending
// bit as they will be after the current edge: same-edge writes are forwarded
// (port 1 over port 0) and a same-edge alloc forces the pending bit high.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = RF_AW,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int IW       = idx_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [DEPTH*DW-1:0]   regs_i,
    input  logic [DEPTH-1:0]      pend_i,
    input  logic [1:0]            wr_eff_i,
    input  logic [2*AW-1:0]       wr_addr_i,
    input  logic [2*DW-1:0]       wr_data_i,
    input  logic                  alloc_eff_i,
    input  logic [AW-1:0]         alloc_addr_i,
    output logic [DW-1:0]         rd_data_o,
    output logic                  rd_pend_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          in_range;
    logic          hit0, hit1, alloc_hit;
    logic [IW-1:0] idx;
    logic [DW-1:0] rd_data_d, rd_data_q;
    logic          rd_pend_d, rd_pend_q;

    // Writes and allocs arrive already qualified (range, zero register), so a
    // plain address match is enough to decide forwarding.
    assign in_range  = ({1'b0, rd_addr_i} < DEPTH_W) &&
                       !((ZERO_REG != 0) && (rd_addr_i == '0));
    assign hit0      = wr_eff_i[0] && (wr_addr_i[0  +: AW] == rd_addr_i);
    assign hit1      = wr_eff_i[1] && (wr_addr_i[AW +: AW] == rd_addr_i);
    assign alloc_hit = alloc_eff_i && (alloc_addr_i == rd_addr_i);
    assign idx       = in_range ? rd_addr_i[IW-1:0] : '0;

    // Post-edge value of the addressed register and its pending bit.
    always_comb begin
        rd_data_d = '0;
        rd_pend_d = 1'b0;
        if (in_range) begin
            if (hit1) begin
                rd_data_d = wr_data_i[DW +: DW];
            end else if (hit0) begin
                rd_data_d = wr_data_i[0 +: DW];
            end else begin
                rd_data_d = regs_i[idx*DW +: DW];
            end
            rd_pend_d = alloc_hit || (!(hit0 || hit1) && pend_i[idx]);
        end
    end

    // Output registers load only on an enabled read, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
            rd_pend_q <= 1'b0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_pend_o = rd_pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports with write-first
// bypass, two write ports (port 1 wins on a clash), optional hardwired zero
// register and a per-register pending bit set by alloc, cleared by writes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = RF_AW,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_RD-1:0]     rd_en,
    input  logic [NUM_RD*AW-1:0]  rd_addr,
    output logic [NUM_RD*DW-1:0]  rd_data,
    output logic [NUM_RD-1:0]     rd_pend,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*DW-1:0]       wr_data,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr
);

    localparam int          IW      = idx_w(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH*DW-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [1:0]          wr_eff;
    logic                alloc_eff;

    // An address is writable when it exists and is not the hardwired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_eff[0] = wr_en[0] && addr_ok(wr_addr[0  +: AW]);
    assign wr_eff[1] = wr_en[1] && addr_ok(wr_addr[AW +: AW]);
    assign alloc_eff = alloc_en && addr_ok(alloc_addr);

    // Next storage state: port 0, then port 1 (so port 1 wins), then alloc
    // last so it overrides the write-clear of the pending bit.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_eff[0]) begin
            regs_d[wr_addr[IW-1:0]*DW +: DW] = wr_data[0 +: DW];
            pend_d[wr_addr[IW-1:0]]          = 1'b0;
        end
        if (wr_eff[1]) begin
            regs_d[wr_addr[AW +: IW]*DW +: DW] = wr_data[DW +: DW];
            pend_d[wr_addr[AW +: IW]]          = 1'b0;
        end
        if (alloc_eff) begin
            pend_d[alloc_addr[IW-1:0]] = 1'b1;
        end
    end

    // Register storage and pending array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .IW       (IW)
        ) u_rd_port (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .rd_en_i      (rd_en[k]),
            .rd_addr_i    (rd_addr[k*AW +: AW]),
            .regs_i       (regs_q),
            .pend_i       (pend_q),
            .wr_eff_i     (wr_eff),
            .wr_addr_i    (wr_addr),
            .wr_data_i    (wr_data),
            .alloc_eff_i  (alloc_eff),
            .alloc_addr_i (alloc_addr),
            .rd_data_o    (rd_data[k*DW +: DW]),
            .rd_pend_o    (rd_pend[k])
        );
    end

endmodule
